regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised integer register file for the pipelined core. It adds to the single-cycle register file a configurable width and depth, an optional write-to-read bypass, a per-register pending-write scoreboard for hazard detection, and a debug read port. It sits in the decode stage: decode reads operands and reserves destinations, and writeback commits results and releases reservations.

## Interface
- XLEN, default 32: data width in bits.
- NREGS, default 32: number of registers; power of two, at least 2. Index width AW = log2(NREGS).
- SP_INDEX, default 2: register loaded with SP_INIT at reset.
- SP_INIT, default 32'h2ffc: stack-pointer reset value, truncated or zero-extended to XLEN.
- BYPASS, default 1: 1 enables same-cycle write-to-read forwarding; 0 disables it.

Ports:
- clk, input, 1: the only clock; all state updates on its rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- rs1, input, AW: read port 1 index.
- rs2, input, AW: read port 2 index.
- rs1_dout, output, XLEN: read port 1 data.
- rs2_dout, output, XLEN: read port 2 data.
- rs1_busy, output, 1: rs1 has an outstanding reserved write.
- rs2_busy, output, 1: rs2 has an outstanding reserved write.
- issue_valid, input, 1: reserve register issue_rd.
- issue_rd, input, AW: register to reserve.
- write_enable, input, 1: writeback commit.
- rd, input, AW: writeback destination.
- rd_din, input, XLEN: writeback data.
- dbg_idx, input, AW: debug read index.
- dbg_dout, output, XLEN: debug read data, with no bypass.
- busy_count, output, AW+1: number of registers currently reserved.

## Operation
- Register 0 is hardwired:
  - reads of register 0 return 0;
  - writes to it are ignored;
  - it is never marked busy;
  - issue_rd = 0 is a no-op.
- Reads are combinational. rsN_dout = rf[rsN].
  - Exception when BYPASS = 1, write_enable = 1, rd = rsN and rd != 0: rsN_dout = rd_din.
- Write: on a rising edge with write_enable = 1 and rd != 0, rf[rd] takes rd_din.
- Scoreboard: busy[NREGS-1:1] flags, updated on every rising edge.
  - A commit to rd clears busy[rd].
  - An issue to issue_rd sets busy[issue_rd].
  - If issue and commit target the same nonzero register in the same cycle, the set wins and busy stays 1, because a younger writer now owns the register.
- rsN_busy = busy[rsN], with one exception: when BYPASS = 1 and a commit to rsN is happening this cycle, rsN_busy = 0 (the value is forwarded).
  - rsN_busy is 0 for index 0.
- An issue to an already-busy register leaves it busy (re-reservation by a younger writer). No error is raised.
- A commit to a register that is not busy is legal; the data is written and busy stays 0.
- busy_count is the population count of busy. It is registered: it changes only at the rising edge or at reset, consistent with the busy flags.
- dbg_idx reads rf directly; index 0 reads 0.

## Timing
- Read latency is 0 cycles (combinational from rsN, rf, and the bypass inputs).
- A write is visible on rsN_dout and dbg_dout from the cycle after the commit edge. With BYPASS = 1 it is also visible in the commit cycle itself, on rsN_dout.
- Issue at edge T: rsN_busy = 1 from after T until the edge that commits that register.
- Reset (reset_n low, asynchronous, any time including mid-operation):
  - every register clears to 0, except rf[SP_INDEX] = SP_INIT;
  - all busy flags clear to 0 and busy_count = 0;
  - pending reservations are discarded.
- While reset_n is low, write_enable and issue_valid are ignored.
- The first edge after reset_n rises behaves normally.
- Outputs during reset:
  - rsN_dout and dbg_dout follow the reset contents (0, or SP_INIT at SP_INDEX);
  - rsN_busy = 0;
  - busy_count = 0.

## Test plan
- Reset with defaults: assert reset_n = 0 mid-cycle. Required: rs1 = 2 gives rs1_dout = 32'h00002ffc; rs2 = 5 gives 0; busy_count = 0; all of this with no clock edge.
- Write/read and x0: commit rd = 5, rd_din = 32'hDEADBEEF, then commit rd = 0, rd_din = 32'h1234. Required: next cycle rs1 = 5 reads DEADBEEF, and rs2 = 0 reads 0.
- Bypass: with BYPASS = 1, commit rd = 7, rd_din = 32'hA5A5A5A5 while rs1 = 7. Required: rs1_dout = A5A5A5A5 in the same cycle. With BYPASS = 0, same stimulus: rs1_dout shows the old value until the next cycle.
- Scoreboard lifecycle: issue rd = 9, then commit rd = 9 three cycles later. Required: rs1_busy = 1 for those cycles and busy_count = 1; then 0 after the commit (and in the commit cycle itself when BYPASS = 1).
- Same-cycle issue and commit: with busy[4] = 1, drive issue_rd = 4 and commit rd = 4 on the same edge. Required: busy[4] stays 1, rf[4] is updated, busy_count is unchanged.
- Parametrised instance XLEN = 64, NREGS = 16: issue 15 distinct nonzero registers. Required: busy_count = 15; then reset_n pulses low mid-cycle and busy_count = 0 asynchronously.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with hardwired x0, optional write-to-read bypass,
// per-register pending-write scoreboard and a debug read port.
module regfile_scoreboard #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned SP_INDEX = 2,
    parameter logic [31:0] SP_INIT  = 32'h2ffc,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_dout,
    output logic [XLEN-1:0] rs2_dout,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            write_enable,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] rd_din,
    input  logic [AW-1:0]   dbg_idx,
    output logic [XLEN-1:0] dbg_dout,
    output logic [AW:0]     busy_count
);

    localparam logic [XLEN-1:0] SP_RESET = XLEN'(SP_INIT);

    logic [XLEN-1:0] rf_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busy_count_q;
    logic [AW:0]      busy_count_d;

    logic commit;
    logic issue;
    logic fwd1;
    logic fwd2;

    // Commits and issues are suppressed while reset is held, including the bypass path.
    assign commit = reset_n && write_enable && (rd != '0);
    assign issue  = reset_n && issue_valid && (issue_rd != '0);
    assign fwd1   = BYPASS && commit && (rd == rs1);
    assign fwd2   = BYPASS && commit && (rd == rs2);

    // Set after clear: a same-cycle issue belongs to a younger writer and keeps the flag.
    always_comb begin
        busy_d = busy_q;
        if (commit) begin
            busy_d[rd] = 1'b0;
        end
        if (issue) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_count_d = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            busy_count_d = busy_count_d + (AW+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf_q[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end
        end else if (commit) begin
            rf_q[rd] <= rd_din;
        end
    end

    always_comb begin
        rs1_dout = '0;
        rs2_dout = '0;
        dbg_dout = '0;
        if (rs1 != '0) begin
            rs1_dout = fwd1 ? rd_din : rf_q[rs1];
        end
        if (rs2 != '0) begin
            rs2_dout = fwd2 ? rd_din : rf_q[rs2];
        end
        if (dbg_idx != '0) begin
            dbg_dout = rf_q[dbg_idx];
        end
    end

    assign rs1_busy   = busy_q[rs1] && !fwd1;
    assign rs2_busy   = busy_q[rs2] && !fwd2;
    assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: bypass and no-bypass 32x32 instances on shared
// stimulus against an array model, plus a 64-bit x 16 instance for scoreboard fill.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [4:0]  rs1, rs2, rd, ird, dbg;
    logic        we, iv;
    logic [31:0] din;

    logic [31:0] d_rs1_dout, d_rs2_dout, d_dbg_dout;
    logic        d_rs1_busy, d_rs2_busy;
    logic [5:0]  d_busy_count;
    logic [31:0] n_rs1_dout, n_rs2_dout, n_dbg_dout;
    logic        n_rs1_busy, n_rs2_busy;
    logic [5:0]  n_busy_count;

    logic        w_reset_n;
    logic [3:0]  w_rs1, w_rs2, w_rd, w_ird, w_dbg;
    logic        w_we, w_iv;
    logic [63:0] w_din;
    logic [63:0] w_rs1_dout, w_rs2_dout, w_dbg_dout;
    logic        w_rs1_busy, w_rs2_busy;
    logic [4:0]  w_busy_count;

    regfile_scoreboard u_dut (
        .clk(clk), .reset_n(reset_n), .rs1(rs1), .rs2(rs2),
        .rs1_dout(d_rs1_dout), .rs2_dout(d_rs2_dout),
        .rs1_busy(d_rs1_busy), .rs2_busy(d_rs2_busy),
        .issue_valid(iv), .issue_rd(ird), .write_enable(we), .rd(rd), .rd_din(din),
        .dbg_idx(dbg), .dbg_dout(d_dbg_dout), .busy_count(d_busy_count)
    );

    regfile_scoreboard #(.BYPASS(1'b0)) u_nb (
        .clk(clk), .reset_n(reset_n), .rs1(rs1), .rs2(rs2),
        .rs1_dout(n_rs1_dout), .rs2_dout(n_rs2_dout),
        .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
        .issue_valid(iv), .issue_rd(ird), .write_enable(we), .rd(rd), .rd_din(din),
        .dbg_idx(dbg), .dbg_dout(n_dbg_dout), .busy_count(n_busy_count)
    );

    regfile_scoreboard #(.XLEN(64), .NREGS(16)) u_wide (
        .clk(clk), .reset_n(w_reset_n), .rs1(w_rs1), .rs2(w_rs2),
        .rs1_dout(w_rs1_dout), .rs2_dout(w_rs2_dout),
        .rs1_busy(w_rs1_busy), .rs2_busy(w_rs2_busy),
        .issue_valid(w_iv), .issue_rd(w_ird), .write_enable(w_we), .rd(w_rd), .rd_din(w_din),
        .dbg_idx(w_dbg), .dbg_dout(w_dbg_dout), .busy_count(w_busy_count)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural model: register contents and reservation flags.
    logic [31:0] m_rf   [32];
    bit          m_busy [32];

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = '0;
            m_busy[i] = 1'b0;
        end
        m_rf[2] = 32'h2ffc;
    endtask

    function automatic logic [31:0] exp_dout(input logic [4:0] idx, input bit byp);
        if (idx == 0) return '0;
        if (byp && reset_n && we && rd == idx) return din;
        return m_rf[idx];
    endfunction

    function automatic logic exp_busy(input logic [4:0] idx, input bit byp);
        if (idx == 0) return 1'b0;
        if (byp && reset_n && we && rd == idx) return 1'b0;
        return m_busy[idx];
    endfunction

    function automatic int unsigned n_busy();
        int unsigned c = 0;
        for (int i = 1; i < 32; i++) c += m_busy[i] ? 1 : 0;
        return c;
    endfunction

    task automatic check_model();
        check_eq("byp_rs1_dout", d_rs1_dout, exp_dout(rs1, 1'b1));
        check_eq("byp_rs2_dout", d_rs2_dout, exp_dout(rs2, 1'b1));
        check_eq("byp_rs1_busy", d_rs1_busy, exp_busy(rs1, 1'b1));
        check_eq("byp_rs2_busy", d_rs2_busy, exp_busy(rs2, 1'b1));
        check_eq("byp_dbg_dout", d_dbg_dout, (dbg == 0) ? 32'h0 : m_rf[dbg]);
        check_eq("byp_busy_count", d_busy_count, 64'(n_busy()));
        check_eq("nb_rs1_dout", n_rs1_dout, exp_dout(rs1, 1'b0));
        check_eq("nb_rs2_dout", n_rs2_dout, exp_dout(rs2, 1'b0));
        check_eq("nb_rs1_busy", n_rs1_busy, exp_busy(rs1, 1'b0));
        check_eq("nb_rs2_busy", n_rs2_busy, exp_busy(rs2, 1'b0));
        check_eq("nb_dbg_dout", n_dbg_dout, (dbg == 0) ? 32'h0 : m_rf[dbg]);
        check_eq("nb_busy_count", n_busy_count, 64'(n_busy()));
    endtask

    // Called at a falling edge: drive one cycle of inputs and compare pre-edge outputs.
    task automatic setup(input logic we_v, input logic [4:0] rd_v, input logic [31:0] din_v,
                         input logic iv_v, input logic [4:0] ird_v,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg_v);
        we = we_v; rd = rd_v; din = din_v; iv = iv_v; ird = ird_v;
        rs1 = r1; rs2 = r2; dbg = dbg_v;
        #2;
        check_model();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (reset_n) begin
            if (we && rd != 0) begin
                m_rf[rd]   = din;
                m_busy[rd] = 1'b0;
            end
            if (iv && ird != 0) m_busy[ird] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; w_reset_n = 1'b0;
        we = 0; rd = 0; din = 0; iv = 0; ird = 0; rs1 = 0; rs2 = 0; dbg = 0;
        w_we = 0; w_rd = 0; w_din = 0; w_iv = 0; w_ird = 0; w_rs1 = 0; w_rs2 = 0; w_dbg = 0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1; w_reset_n = 1'b1;

        setup(0, 0, 0, 0, 0, 5'd2, 5'd5, 5'd2);
        check_eq("init_sp", d_rs1_dout, 64'h2ffc);
        check_eq("init_r5", d_rs2_dout, 64'h0);
        step();

        // Write then attempted write of x0
        setup(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        step();
        setup(1, 5'd0, 32'h1234, 0, 0, 5'd5, 5'd0, 5'd0);
        check_eq("wr_r5", n_rs1_dout, 64'hDEADBEEF);
        check_eq("x0_read", d_rs2_dout, 64'h0);
        step();
        setup(0, 0, 0, 0, 0, 5'd5, 5'd0, 5'd0);
        check_eq("x0_after", d_rs2_dout, 64'h0);
        check_eq("x0_dbg", d_dbg_dout, 64'h0);
        step();

        // Bypass versus no bypass
        setup(1, 5'd7, 32'h11111111, 0, 0, 0, 0, 0);
        step();
        setup(1, 5'd7, 32'hA5A5A5A5, 0, 0, 5'd7, 5'd0, 5'd7);
        check_eq("byp_same_cycle", d_rs1_dout, 64'hA5A5A5A5);
        check_eq("nb_same_cycle", n_rs1_dout, 64'h11111111);
        check_eq("dbg_no_bypass", d_dbg_dout, 64'h11111111);
        step();
        setup(0, 0, 0, 0, 0, 5'd7, 5'd0, 5'd7);
        check_eq("nb_next_cycle", n_rs1_dout, 64'hA5A5A5A5);
        step();

        // Scoreboard lifecycle on register 9
        setup(0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 5'd0);
        check_eq("sb_pre_issue", d_rs1_busy, 64'h0);
        step();
        for (int c = 0; c < 2; c++) begin
            setup(0, 0, 0, 0, 0, 5'd9, 5'd9, 5'd0);
            check_eq("sb_busy", d_rs1_busy, 64'h1);
            check_eq("sb_count", d_busy_count, 64'h1);
            step();
        end
        setup(1, 5'd9, 32'h99, 0, 0, 5'd9, 5'd0, 5'd0);
        check_eq("sb_commit_byp", d_rs1_busy, 64'h0);
        check_eq("sb_commit_nb", n_rs1_busy, 64'h1);
        step();
        setup(0, 0, 0, 0, 0, 5'd9, 5'd0, 5'd0);
        check_eq("sb_released", n_rs1_busy, 64'h0);
        check_eq("sb_count_zero", d_busy_count, 64'h0);
        step();

        // Same-edge issue and commit on register 4
        setup(0, 0, 0, 1, 5'd4, 0, 0, 0);
        step();
        setup(1, 5'd4, 32'hCAFEF00D, 1, 5'd4, 5'd4, 5'd0, 5'd4);
        check_eq("same_cnt_before", d_busy_count, 64'h1);
        step();
        setup(0, 0, 0, 0, 0, 5'd4, 5'd4, 5'd4);
        check_eq("same_busy", d_rs1_busy, 64'h1);
        check_eq("same_data", d_dbg_dout, 64'hCAFEF00D);
        check_eq("same_cnt_after", d_busy_count, 64'h1);
        step();

        // Randomised traffic; reads often aimed at the writeback destination
        for (int k = 0; k < 400; k++) begin
            logic [4:0] r_rd, r_r1, r_r2;
            r_rd = 5'($urandom);
            r_r1 = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom);
            r_r2 = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom);
            setup(1'($urandom), r_rd, $urandom, ($urandom_range(0, 2) == 0),
                  5'($urandom), r_r1, r_r2, 5'($urandom));
            step();
        end

        // Asynchronous reset in mid-cycle with state to discard
        setup(1, 5'd2, 32'h77, 1, 5'd6, 0, 0, 0);
        step();
        setup(0, 0, 0, 0, 0, 5'd6, 5'd2, 5'd0);
        reset_n = 1'b0;
        rs1 = 5'd2; rs2 = 5'd5; dbg = 5'd2;
        #1;
        check_eq("rst_sp", d_rs1_dout, 64'h2ffc);
        check_eq("rst_r5", d_rs2_dout, 64'h0);
        check_eq("rst_dbg", n_dbg_dout, 64'h2ffc);
        check_eq("rst_cnt", d_busy_count, 64'h0);
        check_eq("rst_cnt_nb", n_busy_count, 64'h0);
        m_reset();
        we = 1; rd = 5'd3; din = 32'h55; iv = 1; ird = 5'd3; rs1 = 5'd3;
        #1;
        check_eq("rst_no_bypass", d_rs1_dout, 64'h0);
        check_eq("rst_no_busy", d_rs1_busy, 64'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset_n = 1'b1;
        setup(0, 0, 0, 0, 0, 5'd3, 5'd6, 5'd3);
        check_eq("rst_ignored_wr", d_rs1_dout, 64'h0);
        check_eq("rst_ignored_iss", d_rs1_busy, 64'h0);
        step();
        setup(1, 5'd3, 32'h3333, 1, 5'd8, 5'd3, 5'd8, 5'd3);
        step();
        setup(0, 0, 0, 0, 0, 5'd3, 5'd8, 5'd3);
        step();

        // Wide instance: fill the scoreboard, then reset asynchronously
        for (int i = 1; i < 16; i++) begin
            w_iv = 1'b1; w_ird = 4'(i); w_rs1 = 4'(i);
            #2;
            check_eq("w_fill_cnt", w_busy_count, 64'(i - 1));
            check_eq("w_fill_busy", w_rs1_busy, 64'h0);
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        w_iv = 1'b0; w_ird = '0; w_rs1 = 4'd15; w_rs2 = 4'd2; w_dbg = 4'd2;
        #2;
        check_eq("w_full_cnt", w_busy_count, 64'd15);
        check_eq("w_full_busy", w_rs1_busy, 64'h1);
        check_eq("w_sp", w_rs2_dout, 64'h2ffc);
        w_reset_n = 1'b0;
        #1;
        check_eq("w_rst_cnt", w_busy_count, 64'h0);
        check_eq("w_rst_busy", w_rs1_busy, 64'h0);
        check_eq("w_rst_sp", w_dbg_dout, 64'h2ffc);
        @(negedge clk);
        w_reset_n = 1'b1;
        w_we = 1'b1; w_rd = 4'd15; w_din = 64'hFEDCBA9876543210;
        #2;
        check_eq("w_byp64", w_rs1_dout, 64'hFEDCBA9876543210);
        @(posedge clk);
        #1;
        w_we = 1'b0;
        check_eq("w_wr64", w_rs1_dout, 64'hFEDCBA9876543210);
        check_eq("w_cnt_after", w_busy_count, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
